// File: rtl/life_engine.sv
// rtl/life_engine.sv - Game-of-Life generation engine with double-buffered board
// prev holds the frozen board while curr is rewritten cell by cell from it.
module life_engine #(
  parameter int BIT_WIDTH  = 3,
  parameter int BIT_HEIGHT = 3,
  parameter int WRAP       = 0,
  parameter int GEN_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            run,
  input  logic [8:0]                      birth_mask,
  input  logic [8:0]                      survive_mask,
  input  logic                            wr_en,
  input  logic [BIT_WIDTH+BIT_HEIGHT-1:0] wr_addr,
  input  logic                            wr_data,
  input  logic [BIT_WIDTH+BIT_HEIGHT-1:0] rd_addr,
  output logic                            rd_data,
  output logic                            busy,
  output logic                            done,
  output logic [GEN_W-1:0]                generation,
  output logic [BIT_WIDTH+BIT_HEIGHT:0]   population,
  output logic                            extinct
);
  localparam int AW = BIT_WIDTH + BIT_HEIGHT;
  localparam int N  = 1 << AW;
  localparam int RH = BIT_HEIGHT + 1;
  localparam int RW = BIT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, COPY, COMPUTE} state_t;

  state_t              state_q;
  logic [N-1:0]        curr_q, prev_q;
  logic [AW-1:0]       i_q;
  logic [8:0]          birth_q, survive_q;
  logic [AW:0]         pop_acc_q, population_q;
  logic [GEN_W-1:0]    gen_q;
  logic                busy_q, done_q, extinct_q;

  logic [BIT_HEIGHT-1:0] row;
  logic [BIT_WIDTH-1:0]  col;
  logic [8:0]            nb_alive;
  logic [3:0]            n_count;
  logic                  cell_d;
  logic [AW:0]           pop_acc_d;

  assign row = i_q[AW-1:BIT_WIDTH];
  assign col = i_q[BIT_WIDTH-1:0];

  // Neighbour k sits at offset (k/3-1, k%3-1); the extra top bit flags an off-board row/col.
  for (genvar k = 0; k < 9; k++) begin : g_nb
    localparam int DR = k / 3 - 1;
    localparam int DC = k % 3 - 1;
    if (k == 4) begin : g_self
      assign nb_alive[k] = 1'b0;
    end else if (WRAP != 0) begin : g_wrap
      logic [BIT_HEIGHT-1:0] nr;
      logic [BIT_WIDTH-1:0]  nc;
      assign nr = row + BIT_HEIGHT'(DR);
      assign nc = col + BIT_WIDTH'(DC);
      assign nb_alive[k] = prev_q[{nr, nc}];
    end else begin : g_edge
      logic [BIT_HEIGHT:0] nr;
      logic [BIT_WIDTH:0]  nc;
      assign nr = {1'b0, row} + RH'(DR);
      assign nc = {1'b0, col} + RW'(DC);
      assign nb_alive[k] = !nr[BIT_HEIGHT] && !nc[BIT_WIDTH] &&
                           prev_q[{nr[BIT_HEIGHT-1:0], nc[BIT_WIDTH-1:0]}];
    end
  end

  always_comb begin
    n_count = '0;
    for (int k = 0; k < 9; k++) n_count = n_count + {3'b000, nb_alive[k]};
  end

  assign cell_d    = prev_q[i_q] ? survive_q[n_count] : birth_q[n_count];
  assign pop_acc_d = pop_acc_q + {{AW{1'b0}}, cell_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      curr_q       <= '0;
      prev_q       <= '0;
      i_q          <= '0;
      birth_q      <= '0;
      survive_q    <= '0;
      pop_acc_q    <= '0;
      population_q <= '0;
      gen_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      extinct_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_en) curr_q[wr_addr] <= wr_data;
          if (start && run) begin
            birth_q   <= birth_mask;
            survive_q <= survive_mask;
            i_q       <= '0;
            pop_acc_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= COPY;
          end
        end
        COPY: begin
          prev_q[i_q] <= curr_q[i_q];
          i_q         <= i_q + 1'b1;
          if (&i_q) state_q <= COMPUTE;
        end
        COMPUTE: begin
          curr_q[i_q] <= cell_d;
          pop_acc_q   <= pop_acc_d;
          i_q         <= i_q + 1'b1;
          if (&i_q) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            gen_q        <= gen_q + 1'b1;
            population_q <= pop_acc_d;
            extinct_q    <= (pop_acc_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // While curr is being rewritten the display shows the untouched previous board.
  assign rd_data    = (state_q == COMPUTE) ? prev_q[rd_addr] : curr_q[rd_addr];
  assign busy       = busy_q;
  assign done       = done_q;
  assign generation = gen_q;
  assign population = population_q;
  assign extinct    = extinct_q;
endmodule

// File: tb/tb_life_engine.sv
// tb/tb_life_engine.sv - scoreboard bench for life_engine, bounded and toroidal instances
module tb_life_engine;
  localparam int AW = 6;
  localparam int N  = 64;
  localparam int GW = 16;
  localparam logic [8:0] CONWAY_B = 9'h008, CONWAY_S = 9'h00C, HL_B = 9'h048;

  logic clk = 1'b0;
  logic reset, start, run, wr_en, wr_data;
  logic [8:0] birth_mask, survive_mask;
  logic [AW-1:0] wr_addr, rd_addr;
  logic rd_data0, rd_data1, busy0, busy1, done0, done1, extinct0, extinct1;
  logic [GW-1:0] gen0, gen1;
  logic [AW:0] pop0, pop1;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  life_engine #(.BIT_WIDTH(3), .BIT_HEIGHT(3), .WRAP(0), .GEN_W(GW)) u0 (
    .clk(clk), .reset(reset), .start(start), .run(run), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0), .busy(busy0), .done(done0),
    .generation(gen0), .population(pop0), .extinct(extinct0));

  life_engine #(.BIT_WIDTH(3), .BIT_HEIGHT(3), .WRAP(1), .GEN_W(GW)) u1 (
    .clk(clk), .reset(reset), .start(start), .run(run), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1), .busy(busy1), .done(done1),
    .generation(gen1), .population(pop1), .extinct(extinct1));

  typedef struct {
    int            exp_cyc;
    logic [63:0]   b0;
    logic [63:0]   b1;
    logic [GW-1:0] gen;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, n_checked = 0;
  logic [63:0] m0, m1, last0, last1;
  logic [GW-1:0] m_gen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: apply the birth/survive rule to every cell of an 8x8 board.
  function automatic logic [63:0] life_step(input logic [63:0] b, input bit wrap,
                                            input logic [8:0] bm, input logic [8:0] sm);
    logic [63:0] nx;
    int n, rr, cc;
    nx = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              n += int'(b[rr*8+cc]);
          end
        end
        nx[r*8+c] = b[r*8+c] ? sm[n] : bm[n];
      end
    end
    return nx;
  endfunction

  task automatic read_board(output logic [63:0] a0, output logic [63:0] a1);
    for (int a = 0; a < N; a++) begin
      rd_addr = AW'(a);
      #1;
      a0[a] = rd_data0;
      a1[a] = rd_data1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (done0 || done1)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done0=%0b done1=%0b with no generation pending", done0, done1);
        end else begin
          e = sb.pop_front();
          check("done_latency_cycle", 64'(cyc), 64'(e.exp_cyc));
          check("done_pair", {done0, done1}, 2'b11);
          check("generation0", gen0, e.gen);
          check("generation1", gen1, e.gen);
          check("population0", pop0, $countones(e.b0));
          check("population1", pop1, $countones(e.b1));
          check("extinct0", extinct0, e.b0 == 0);
          check("extinct1", extinct1, e.b1 == 0);
          @(negedge clk);
          check("done_pulse_width", {done0, done1}, 2'b00);
          read_board(last0, last1);
          check("board0", last0, e.b0);
          check("board1", last1, e.b1);
          n_checked++;
        end
      end
    end
  end

  task automatic seed(input logic [63:0] b);
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = b[a];
    end
    @(negedge clk);
    wr_en = 1'b0;
    m0 = b;
    m1 = b;
  endtask

  task automatic wait_checked(input int target);
    int k;
    k = 0;
    while (n_checked < target && k < 4*N + 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (n_checked < target) begin
      n_bad++;
      $display("FAIL done_timeout: checked=%0d required=%0d", n_checked, target);
    end
  endtask

  task automatic do_gen(input logic [8:0] b, input logic [8:0] s, input bit extras);
    int target;
    @(negedge clk);
    birth_mask = b;
    survive_mask = s;
    run = 1'b1;
    start = 1'b1;
    m0 = life_step(m0, 1'b0, b, s);
    m1 = life_step(m1, 1'b1, b, s);
    m_gen++;
    sb.push_back('{exp_cyc: cyc + 1 + 2*N, b0: m0, b1: m1, gen: m_gen});
    target = n_checked + 1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {busy0, busy1}, 2'b11);
    if (extras) begin
      birth_mask = 9'($urandom);
      survive_mask = 9'($urandom);
      for (int k = 2; k <= 45; k++) begin
        @(negedge clk);
        start = (k == 5 || k == 40);
        wr_en = (k == 10);
        if (k == 10) begin
          wr_addr = AW'($urandom);
          wr_data = ~m0[wr_addr];
        end
      end
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
    end
    wait_checked(target);
    check("busy_idle", {busy0, busy1}, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m0 = '0;
    m1 = '0;
    m_gen = '0;
  endtask

  logic [63:0] glider, board;
  initial begin : stimulus
    reset = 1'b1; start = 1'b0; run = 1'b1; wr_en = 1'b0; wr_data = 1'b0;
    wr_addr = '0; rd_addr = '0; birth_mask = CONWAY_B; survive_mask = CONWAY_S;
    m0 = '0; m1 = '0; m_gen = '0;
    repeat (3) @(negedge clk);
    check("reset_busy_done", {busy0, done0, busy1, done1}, 4'b0000);
    check("reset_generation", {gen0, gen1}, 32'h0);
    check("reset_population", {pop0, pop1}, 14'h0);
    check("reset_extinct", {extinct0, extinct1}, 2'b11);
    @(negedge clk);
    reset = 1'b0;

    // Blinker plus ignored start/write pulses while busy.
    seed(64'h0000_0000_3800_0000);
    do_gen(CONWAY_B, CONWAY_S, 1'b1);
    check("blinker_board", last0, 64'h0000_0010_1010_0000);

    // Glider on the torus returns home after 32 generations.
    do_reset();
    glider = '0;
    glider[46] = 1'b1; glider[55] = 1'b1; glider[61] = 1'b1; glider[62] = 1'b1; glider[63] = 1'b1;
    seed(glider);
    for (int g = 0; g < 32; g++) do_gen(CONWAY_B, CONWAY_S, 1'b0);
    check("glider_return", last1, glider);
    check("glider_generation", gen1, 32);

    // Dead cell 27 with six live neighbours: born under HighLife only.
    board = '0;
    board[18] = 1'b1; board[19] = 1'b1; board[20] = 1'b1;
    board[26] = 1'b1; board[28] = 1'b1; board[34] = 1'b1;
    seed(board);
    do_gen(HL_B, CONWAY_S, 1'b0);
    check("highlife_cell27", last0[27], 1'b1);
    seed(board);
    do_gen(CONWAY_B, CONWAY_S, 1'b0);
    check("conway_cell27", last0[27], 1'b0);

    // Lone cell dies out.
    board = '0;
    board[$urandom_range(0, 63)] = 1'b1;
    seed(board);
    do_gen(CONWAY_B, CONWAY_S, 1'b0);
    check("single_extinct", {extinct0, extinct1}, 2'b11);
    check("single_population", {pop0, pop1}, 14'h0);

    // Frozen: starts with run low are ignored.
    @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      start = (k % 2 == 0);
      @(negedge clk);
      check("frozen_busy", {busy0, busy1}, 2'b00);
    end
    start = 1'b0;
    run = 1'b1;
    check("frozen_generation", gen0, m_gen);

    for (int t = 0; t < 4; t++) begin
      seed({$urandom, $urandom});
      do_gen(9'($urandom), 9'($urandom), 1'($urandom));
      do_gen(CONWAY_B, CONWAY_S, 1'b0);
    end

    // Reset in the middle of a generation, then restart in the first idle cycle.
    seed({$urandom, $urandom});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (69) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_busy_done", {busy0, done0, busy1, done1}, 4'b0000);
    check("midreset_generation", {gen0, gen1}, 32'h0);
    check("midreset_population", {pop0, pop1}, 14'h0);
    check("midreset_extinct", {extinct0, extinct1}, 2'b11);
    read_board(last0, last1);
    check("midreset_rd0", last0, 64'h0);
    check("midreset_rd1", last1, 64'h0);
    m0 = '0; m1 = '0; m_gen = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    do_gen(CONWAY_B, CONWAY_S, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end
endmodule
